layer_out_serializer: RTL

Converts the parallel outputs of one fully-connected layer's neurons into the serial `myinput`/`myinputValid` stream consumed by every neuron of the next layer. It captures all `numNeurons` neuron outputs when the layer signals valid, then emits them one per cycle, neuron 0 first. A one-frame shadow buffer absorbs a new layer result that arrives while a stream is still in progress. The block sits between layer N's neuron array and layer N+1's neuron array.

---
 rtl/layer_out_serializer.sv | 99 +++++++++
 1 files changed

// File: rtl/layer_out_serializer.sv
// layer_out_serializer: captures a layer's parallel neuron outputs and streams them one word per cycle, with a one-frame shadow buffer.
module layer_out_serializer #(
    parameter int numNeurons = 30,
    parameter int dataWidth  = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [numNeurons*dataWidth-1:0]  neuron_out,
    input  logic [numNeurons-1:0]            neuron_valid,
    output logic [dataWidth-1:0]             out_data,
    output logic                             out_valid,
    output logic                             busy,
    output logic                             overrun,
    output logic                             valid_mismatch
);
    localparam int IW = $clog2(numNeurons);
    localparam logic [IW-1:0] LAST = IW'(numNeurons - 1);
    typedef enum logic {IDLE, STREAM} state_t;
    typedef logic [numNeurons-1:0][dataWidth-1:0] frame_t;
    state_t               state_q, state_d;
    logic [IW-1:0]        idx_q, idx_d;
    frame_t               active_q, active_d, shadow_q, shadow_d;
    logic                 shadow_full_q, shadow_full_d;
    logic [dataWidth-1:0] out_data_q, out_data_d;
    logic                 out_valid_q, out_valid_d, busy_q, busy_d;
    logic                 overrun_q, overrun_d, mismatch_q, mismatch_d;
    logic                 cap, last;
    assign cap = neuron_valid[0];
    assign last = idx_q == LAST;
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        active_d      = active_q;
        shadow_d      = shadow_q;
        shadow_full_d = shadow_full_q;
        overrun_d     = overrun_q;
        mismatch_d    = mismatch_q | ((|neuron_valid) & ~(&neuron_valid));
        out_valid_d   = state_q == STREAM;
        out_data_d    = out_valid_d ? active_q[idx_q] : '0;
        busy_d        = (state_q == STREAM) | shadow_full_q;
        if (state_q == IDLE) begin
            if (cap) begin
                active_d = frame_t'(neuron_out);
                idx_d    = '0;
                state_d  = STREAM;
            end
        end else if (last) begin
            // a held shadow frame takes priority; a same-cycle capture then refills the shadow
            if (shadow_full_q) begin
                active_d = shadow_q;
                idx_d    = '0;
                if (cap) shadow_d = frame_t'(neuron_out);
                else shadow_full_d = 1'b0;
            end else if (cap) begin
                active_d = frame_t'(neuron_out);
                idx_d    = '0;
            end else begin
                state_d = IDLE;
            end
        end else begin
            idx_d = idx_q + 1'b1;
            if (cap && shadow_full_q) overrun_d = 1'b1;
            else if (cap) begin
                shadow_d      = frame_t'(neuron_out);
                shadow_full_d = 1'b1;
            end
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            shadow_full_q <= 1'b0;
            out_data_q    <= '0;
            out_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            overrun_q     <= 1'b0;
            mismatch_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            shadow_full_q <= shadow_full_d;
            out_data_q    <= out_data_d;
            out_valid_q   <= out_valid_d;
            busy_q        <= busy_d;
            overrun_q     <= overrun_d;
            mismatch_q    <= mismatch_d;
        end
    end
    always_ff @(posedge clk) begin
        active_q <= active_d;
        shadow_q <= shadow_d;
    end
    assign out_data       = out_data_q;
    assign out_valid      = out_valid_q;
    assign busy           = busy_q;
    assign overrun        = overrun_q;
    assign valid_mismatch = mismatch_q;
endmodule
